// File: rtl/dec_ascii_tx.sv
// Unsigned 32-bit binary to decimal ASCII serializer.
// Digits are found by repeated subtraction of powers of ten, most significant digit first.
module dec_ascii_tx #(
  parameter bit NL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] val,
  input  logic        val_valid,
  output logic        val_ack,
  output logic [7:0]  tx_byte,
  output logic        tx_rdy,
  input  logic        tx_re,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StDigit, StEmit, StNl} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        started_q, started_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [31:0] pow_k;

  function automatic logic [31:0] pow10(input logic [3:0] k);
    logic [31:0] p;
    case (k)
      4'd0:    p = 32'd1;
      4'd1:    p = 32'd10;
      4'd2:    p = 32'd100;
      4'd3:    p = 32'd1000;
      4'd4:    p = 32'd10000;
      4'd5:    p = 32'd100000;
      4'd6:    p = 32'd1000000;
      4'd7:    p = 32'd10000000;
      4'd8:    p = 32'd100000000;
      4'd9:    p = 32'd1000000000;
      default: p = 32'd1;
    endcase
    return p;
  endfunction

  assign pow_k   = pow10(k_q);
  assign tx_byte = tx_byte_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    tx_byte_d = tx_byte_q;
    val_ack   = 1'b0;
    tx_rdy    = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy    = 1'b0;
        // Reset holds the FSM in idle; never acknowledge a value that is not captured.
        val_ack = val_valid && !rst;
        if (val_valid) begin
          rem_d     = val;
          k_d       = 4'd9;
          cnt_d     = 4'd0;
          started_d = 1'b0;
          state_d   = StDigit;
        end
      end
      StDigit: begin
        if (rem_q >= pow_k) begin
          rem_d = rem_q - pow_k;
          cnt_d = cnt_q + 4'd1;
        end else if (cnt_q != 4'd0 || started_q || k_q == 4'd0) begin
          tx_byte_d = 8'h30 + {4'h0, cnt_q};
          started_d = 1'b1;
          state_d   = StEmit;
        end else begin
          // Leading zero: skip this position without emitting.
          k_d = k_q - 4'd1;
        end
      end
      StEmit: begin
        tx_rdy = 1'b1;
        if (tx_re) begin
          if (k_q != 4'd0) begin
            k_d     = k_q - 4'd1;
            cnt_d   = 4'd0;
            state_d = StDigit;
          end else if (NL_EN) begin
            tx_byte_d = 8'h0A;
            state_d   = StNl;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StNl: begin
        tx_rdy = 1'b1;
        if (tx_re) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= 32'd0;
      k_q       <= 4'd0;
      cnt_q     <= 4'd0;
      started_q <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      tx_byte_q <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_dec_ascii_tx.sv
// Bench for dec_ascii_tx: instance 1 has the newline terminator, instance 0 does not.
// Expected bytes are queued at capture and compared as each byte is consumed.
module tb_dec_ascii_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] val       [2];
  logic        val_valid [2];
  logic        val_ack   [2];
  logic [7:0]  tx_byte   [2];
  logic        tx_rdy    [2];
  logic        tx_re     [2];
  logic        busy      [2];

  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pop = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dec_ascii_tx #(
      .NL_EN(g == 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .val      (val[g]),
      .val_valid(val_valid[g]),
      .val_ack  (val_ack[g]),
      .tx_byte  (tx_byte[g]),
      .tx_rdy   (tx_rdy[g]),
      .tx_re    (tx_re[g]),
      .busy     (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decimal formatting by division, independent of the DUT's subtraction scheme.
  task automatic push_exp(input logic [31:0] v, input bit nl);
    logic [7:0]  digs [$];
    logic [31:0] x = v;
    do begin
      digs.push_front(8'(32'h30 + x % 10));
      x = x / 10;
    end while (x != 0);
    foreach (digs[i]) exp_q.push_back(digs[i]);
    if (nl) exp_q.push_back(8'h0A);
  endtask

  // Consumption happens at the next rising edge when tx_rdy && tx_re at the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && tx_rdy[d] && tx_re[d]) begin
        check_eq("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("tx_byte", 32'(tx_byte[d]), 32'(exp_q.pop_front()));
        n_pop++;
      end
    end
  end

  task automatic send(input int d, input logic [31:0] v);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    val[d]       = v;
    val_valid[d] = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (val_ack[d]) begin
        got = 1'b1;
        check_eq("ack_when_idle", 32'(busy[d]), 32'd0);
        push_exp(v, d == 1);
      end
    end
    check_eq("ack_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    val_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy[d]) break;
    end
    check_eq("drained", 32'(exp_q.size()), 32'd0);
    check_eq("busy_end", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    for (int d = 0; d < 2; d++) begin
      val[d]       = 32'd0;
      val_valid[d] = 1'b0;
      tx_re[d]     = 1'b1;
    end
    val_valid[1] = 1'b1;
    #23;
    check_eq("rst_tx_rdy", 32'(tx_rdy[1]), 32'd0);
    check_eq("rst_busy", 32'(busy[1]), 32'd0);
    check_eq("rst_tx_byte", 32'(tx_byte[1]), 32'd0);
    check_eq("rst_val_ack", 32'(val_ack[1]), 32'd0);
    val_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero: minimum latency, single "0" then newline.
    send(1, 32'd0);
    lat = 0;
    for (int i = 0; i < 40 && !tx_rdy[1]; i++) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency_zero", 32'(lat), 32'd11);
    wait_done(1);

    send(1, 32'd142);
    wait_done(1);
    send(1, 32'hFFFF_FFFF);
    wait_done(1);
    send(1, 32'd1000000000);
    wait_done(1);

    // Hold the first byte of 305 with tx_re low.
    tx_re[1] = 1'b0;
    send(1, 32'd305);
    for (int i = 0; i < 60 && !tx_rdy[1]; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_byte", 32'(tx_byte[1]), 32'h33);
      check_eq("hold_rdy", 32'(tx_rdy[1]), 32'd1);
    end
    @(posedge clk);
    #1 tx_re[1] = 1'b1;
    wait_done(1);

    // Irregular read enable over a longer stream.
    send(1, 32'd90817263);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1 tx_re[1] = 1'($urandom_range(0, 1));
    end
    tx_re[1] = 1'b1;
    wait_done(1);

    // Abort 12345 after "12" has been consumed.
    base = n_pop;
    send(1, 32'd12345);
    for (int i = 0; i < 200 && n_pop < base + 2; i++) @(negedge clk);
    check_eq("two_popped", 32'(n_pop - base), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_tx_rdy", 32'(tx_rdy[1]), 32'd0);
    check_eq("abort_busy", 32'(busy[1]), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(1, 32'd9);
    wait_done(1);

    // No terminator; a second value waits until idle.
    tx_re[0] = 1'b0;
    send(0, 32'd100);
    val[0]       = 32'd7;
    val_valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("no_ack_busy", 32'(val_ack[0]), 32'd0);
    end
    @(posedge clk);
    #1 tx_re[0] = 1'b1;
    lat = 0;
    for (int i = 0; i < 300 && lat == 0; i++) begin
      @(negedge clk);
      if (val_ack[0]) begin
        lat = 1;
        check_eq("ack_after_idle", 32'(busy[0]), 32'd0);
        check_eq("first_done", 32'(exp_q.size()), 32'd0);
        push_exp(32'd7, 1'b0);
      end
    end
    check_eq("second_ack", 32'(lat), 32'd1);
    @(posedge clk);
    #1 val_valid[0] = 1'b0;
    wait_done(0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dec_ascii_tx.md
DEC_ASCII_TX -- requirements
Module: dec_ascii_tx

Interface
REQ-001 Parameter: NL_EN, default 1, append "\n" (0x0A) after the last digit when 1; no terminator when 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 val  in  32  unsigned binary value to print in decimal.
REQ-005 val_valid  in  1  val is presented.
REQ-006 val_ack  out  1  combinational; high exactly when val is captured this cycle.
REQ-007 tx_byte  out  8  ASCII output byte; valid whenever tx_rdy is high, no read pulse needed.
REQ-008 tx_rdy  out  1  tx_byte holds an unconsumed byte.
REQ-009 tx_re  in  1  consumer read enable; a byte is consumed on any rising edge with tx_rdy && tx_re.
REQ-010 busy  out  1  high from capture until the final byte is consumed.

Function
REQ-011 States: IDLE, DIGIT, EMIT, NL; registered state, remainder rem[31:0], position k[3:0] (9..0), digit count cnt[3:0], started flag.
REQ-012 IDLE: val_ack = val_valid; on ack edge rem<=val, k<=9, cnt<=0, started<=0, state<=DIGIT; busy=0, tx_rdy=0.
REQ-013 val_valid outside IDLE is ignored; val_ack stays 0; val is not sampled.
REQ-014 DIGIT, rem >= 10^k (32-bit constant table 10^0..10^9): rem<=rem-10^k, cnt<=cnt+1, stay in DIGIT; one subtraction per cycle.
REQ-015 DIGIT, rem < 10^k, and cnt!=0 or started or k==0: tx_byte<=0x30+cnt, started<=1, state<=EMIT.
REQ-016 DIGIT, rem < 10^k, cnt==0, !started, k!=0: leading zero suppressed, k<=k-1, stay in DIGIT.
REQ-017 DIGIT occupies exactly (digit value + 1) cycles per position; top digit is never above 4.
REQ-018 EMIT: tx_rdy=1; tx_byte stable until consumed; tx_re while tx_rdy=0 is ignored.
REQ-019 EMIT consume with k!=0: k<=k-1, cnt<=0, state<=DIGIT.
REQ-020 EMIT consume with k==0: state<=NL if NL_EN=1, else IDLE.
REQ-021 NL: tx_byte=0x0A, tx_rdy=1 until consumed; on consume, state<=IDLE.
REQ-022 busy=1 in DIGIT, EMIT and NL; 0 in IDLE.
REQ-023 val=0 emits exactly one "0" (0x30) through the k==0 rule.
REQ-024 No byte is duplicated or dropped under any tx_re pattern; each byte is delivered exactly once.
REQ-025 Minimum capture-to-first-tx_rdy latency is 11 cycles (val=0); re-capture is possible the cycle after return to IDLE.

Reset
REQ-026 rst=1 immediately forces state=IDLE, tx_rdy=0, busy=0, tx_byte=0x00, rem=0, k=0, cnt=0, started=0; val_ack=0 while rst is high.
REQ-027 Reset mid-conversion aborts it; no residual bytes are emitted after release; the first capture after release behaves as a fresh conversion.

Verification
REQ-028 val=0, tx_re=1 constant -> val_ack 1 cycle, bytes 0x30,0x0A, busy low after 0x0A is consumed.
REQ-029 val=142, tx_re=1 -> "1","4","2","\n" (0x31,0x34,0x32,0x0A); no leading-zero bytes.
REQ-030 val=0xFFFFFFFF -> "4294967295\n"; val=1000000000 -> "1000000000\n" (internal zeros are kept).
REQ-031 val=305, tx_re low 5 cycles while the "3" is pending -> tx_byte=0x33 and tx_rdy=1 held all 5 cycles; stream still "305\n" exactly once.
REQ-032 val=12345, rst pulsed after "12" is consumed -> tx_rdy/busy drop in the same cycle as rst; then val=9 -> "9\n" only.
REQ-033 NL_EN=0, val=100, second val_valid asserted while busy -> "1","0","0" with no 0x0A; no val_ack until IDLE; the second value then prints.
